// File: rtl/memory_board_if.sv
// Handshake bundle between the memory-game controller and its board/button front end.
interface memory_board_if;
   logic        btn_up;
   logic        btn_down;
   logic        btn_left;
   logic        btn_right;
   logic        btn_sel;
   logic        start;
   logic [47:0] deck;
   logic [3:0]  cursor_pos;
   logic [15:0] face_up;
   logic [15:0] matched;
   logic [7:0]  moves;
   logic        game_done;
   logic        busy;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_sel, start, deck,
      input  cursor_pos, face_up, matched, moves, game_done, busy
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_sel, start, deck,
      output cursor_pos, face_up, matched, moves, game_done, busy
   );
endinterface

// File: rtl/memory_board_ctrl.sv
// 4x4 memory (pairs) game controller: cursor, card flipping, match check,
// timed flip-back of mismatched pairs and move counting.
module memory_board_ctrl #(
   parameter int FLIP_DELAY = 25000000
) (
   input  logic           clk,
   input  logic           rst_n,
   memory_board_if.slave  bus
);

   localparam int TW = $clog2(FLIP_DELAY);

   typedef enum logic [2:0] {
      PLAY0, PLAY1, CHECK, SHOW, DONE
   } state_t;

   state_t          state, state_n;
   logic [3:0]      cur, cur_n;
   logic [15:0]     face, face_n;
   logic [15:0]     mat, mat_n;
   logic [7:0]      moves, moves_n;
   logic [3:0]      pairs, pairs_n;
   logic [TW-1:0]   timer, timer_n;
   logic [3:0]      first, first_n;
   logic [3:0]      second, second_n;
   logic [47:0]     deck_q, deck_n;
   logic            done_q, busy_q;

   function automatic logic [2:0] card_id(logic [47:0] d, logic [3:0] k);
      return d[6'(k) * 6'd3 +: 3];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= PLAY0;
         cur    <= '0;
         face   <= '0;
         mat    <= '0;
         moves  <= '0;
         pairs  <= '0;
         timer  <= '0;
         first  <= '0;
         second <= '0;
         deck_q <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         cur    <= cur_n;
         face   <= face_n;
         mat    <= mat_n;
         moves  <= moves_n;
         pairs  <= pairs_n;
         timer  <= timer_n;
         first  <= first_n;
         second <= second_n;
         deck_q <= deck_n;
         done_q <= (state_n == DONE);
         busy_q <= (state_n == CHECK) || (state_n == SHOW);
      end
   end

   always_comb begin
      state_n  = state;
      cur_n    = cur;
      face_n   = face;
      mat_n    = mat;
      moves_n  = moves;
      pairs_n  = pairs;
      timer_n  = timer;
      first_n  = first;
      second_n = second;
      deck_n   = deck_q;
      if (bus.start) begin
         deck_n  = bus.deck;
         face_n  = '0;
         mat_n   = '0;
         moves_n = '0;
         pairs_n = '0;
         timer_n = '0;
         cur_n   = '0;
         state_n = PLAY0;
      end else begin
         // Select below uses the pre-move cursor (cur), not cur_n.
         if (state != DONE) begin
            if (bus.btn_up)
               cur_n = {cur[3:2] - 2'd1, cur[1:0]};
            else if (bus.btn_down)
               cur_n = {cur[3:2] + 2'd1, cur[1:0]};
            else if (bus.btn_left)
               cur_n = {cur[3:2], cur[1:0] - 2'd1};
            else if (bus.btn_right)
               cur_n = {cur[3:2], cur[1:0] + 2'd1};
         end
         unique case (state)
            PLAY0: begin
               if (bus.btn_sel && !face[cur]) begin
                  face_n[cur] = 1'b1;
                  first_n     = cur;
                  state_n     = PLAY1;
               end
            end
            PLAY1: begin
               if (bus.btn_sel && !face[cur]) begin
                  face_n[cur] = 1'b1;
                  second_n    = cur;
                  if (moves != 8'hFF)
                     moves_n = moves + 8'd1;
                  state_n = CHECK;
               end
            end
            CHECK: begin
               if (card_id(deck_q, first) == card_id(deck_q, second)) begin
                  mat_n[first]  = 1'b1;
                  mat_n[second] = 1'b1;
                  pairs_n       = pairs + 4'd1;
                  state_n       = (pairs_n == 4'd8) ? DONE : PLAY0;
               end else begin
                  timer_n = TW'(FLIP_DELAY - 1);
                  state_n = SHOW;
               end
            end
            SHOW: begin
               if (timer == '0) begin
                  face_n[first]  = 1'b0;
                  face_n[second] = 1'b0;
                  state_n        = PLAY0;
               end else begin
                  timer_n = timer - 1'b1;
               end
            end
            DONE: ;
            default: state_n = PLAY0;
         endcase
      end
   end

   assign bus.cursor_pos = cur;
   assign bus.face_up    = face;
   assign bus.matched    = mat;
   assign bus.moves      = moves;
   assign bus.game_done  = done_q;
   assign bus.busy       = busy_q;

endmodule

// File: doc/memory_board_ctrl.md
MEMORY_BOARD_CTRL -- requirements
Module: memory_board_ctrl

Interface
REQ-001 Parameter FLIP_DELAY, default 25000000, number of clock cycles a mismatched pair stays face up (at least 2).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 btn_up, btn_down, btn_left, btn_right  input  1 each  debounced single-cycle cursor-move pulses.
REQ-005 btn_sel  input  1  debounced single-cycle pulse that flips the card under the cursor.
REQ-006 start  input  1  single-cycle pulse that restarts the game and loads the deck.
REQ-007 deck  input  48  pair id for each card, 3 bits per card; card k uses bits [3k+2:3k].
REQ-008 cursor_pos  output  4  cursor position {row[1:0], col[1:0]}; 0 is top-left, 15 is bottom-right; drives the card renderer's pos input.
REQ-009 face_up  output  16  bit k is 1 when card k shows its face (includes matched cards).
REQ-010 matched  output  16  bit k is 1 when card k belongs to a matched pair.
REQ-011 moves  output  8  count of completed two-card attempts, saturating at 255.
REQ-012 game_done  output  1  high while in state DONE.
REQ-013 busy  output  1  high in states CHECK and SHOW.

Function
REQ-014 FSM states: PLAY0 (no unmatched card up), PLAY1 (one unmatched card up), CHECK, SHOW, DONE.
REQ-015 Cursor moves by one cell per pulse, wrapping within its row or column: left at col 0 goes to col 3, right at col 3 goes to col 0, up at row 0 goes to row 3, down at row 3 goes to row 0.
REQ-016 When several direction pulses arrive in one cycle, only one is applied, in priority up > down > left > right.
REQ-017 Cursor movement is accepted in every state except DONE.
REQ-018 When btn_sel and a direction pulse arrive in the same cycle, btn_sel acts on the pre-move cursor and the move is still applied.
REQ-019 PLAY0: btn_sel on a card with face_up=0 sets face_up[cursor], latches first=cursor, next state PLAY1.
REQ-020 PLAY1: btn_sel on a card with face_up=0 sets face_up[cursor], latches second=cursor, increments moves (saturating), next state CHECK.
REQ-021 btn_sel on a card that is already face up, and btn_sel in CHECK, SHOW or DONE, has no effect.
REQ-022 CHECK lasts exactly 1 cycle and compares the latched pair ids of first and second.
REQ-023 CHECK, ids equal: set matched[first] and matched[second], increment the 4-bit pair count; next state DONE if the count reaches 8, otherwise PLAY0.
REQ-024 CHECK, ids unequal: load the timer with FLIP_DELAY-1, next state SHOW.
REQ-025 SHOW decrements the timer every cycle; in the cycle the timer is 0, clear face_up[first] and face_up[second] and go to PLAY0, so the mismatched pair is visible for exactly FLIP_DELAY cycles in SHOW.
REQ-026 start is a synchronous action that takes priority over all other inputs in any state: latch deck into an internal register, clear face_up, matched, moves, the pair count and the timer, set cursor_pos=0, next state PLAY0.
REQ-027 Only the deck value latched at start is used; later changes to deck have no effect until the next start.
REQ-028 The deck is not checked for validity; an invalid deck must not hang the FSM.
REQ-029 All outputs are registered, with no combinational path from any input to any output.

Reset
REQ-030 When rst_n=0, asynchronously set state=PLAY0, cursor_pos=0, face_up=0, matched=0, moves=0, game_done=0, busy=0, pair count=0, timer=0, and latched deck=0.
REQ-031 Releasing reset in the middle of a game leaves the block in its reset state; a start pulse is needed to load a deck.

Verification
REQ-032 Cursor: after reset, 1 btn_left -> cursor_pos=3; then 1 btn_up -> cursor_pos=15; btn_up and btn_right in the same cycle -> only up is applied, cursor_pos=11.
REQ-033 Match: deck with card0 and card1 both id 5, start, sel at 0, right, sel at 1 -> matched=16'h0003, face_up=16'h0003, moves=1, busy high for exactly 1 cycle, then PLAY0.
REQ-034 Mismatch: FLIP_DELAY=4, cards 0 and 1 with ids 1 and 2, select both -> face_up=16'h0003 during CHECK plus 4 SHOW cycles, then face_up=0, matched=0; btn_sel during SHOW is ignored.
REQ-035 Full game: select all 8 pairs correctly -> game_done=1 after the 8th CHECK, moves=8; further btn_sel and direction pulses are ignored until start, which clears everything.
REQ-036 Saturation and reselect: 300 mismatched attempts -> moves stays at 255; btn_sel on an already face-up card in PLAY1 -> no state change and moves unchanged.
REQ-037 Reset mid-SHOW: drop rst_n with the timer mid-count -> all outputs reach their reset values immediately; after release, start with a new deck begins a clean game.
